mem_ctrl: RTL and testbench

Memory controller sitting between the instruction fetcher / load-store buffer and the 8-bit external RAM bus.
- Arbitrates fetch and load/store requests and serialises each access into 1, 2 or 4 byte cycles.
- Assembles little-endian read data and returns it zero-extended.
- The sign-extension stage downstream widens loaded data to register width.

---
 rtl/mem_ctrl_pkg.sv | 41 ++++
 rtl/mem_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: constants and types shared by the memory controller.
//   - address/register widths and the matching typedefs
//   - access size encodings carried on lsb_size
//   - the IO region predicate over address bits [17:16]
//   - the controller FSM state encoding
package mem_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] reg_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Address bits [17:16] equal to this value select the IO region.
  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_e;

  // Takes only address bits [17:16].
  function automatic logic is_io(input logic [1:0] region_bits);
    return region_bits == IO_REGION;
  endfunction

  // Index of the last byte of an access; the illegal size 2'b11 is a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 2'd0;
      SIZE_HALF: return 2'd1;
      default:   return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the fetch unit / load-store
// buffer and an 8-bit RAM bus.
//   clk_in, rst_in (sync, active high), rdy_in (0 = freeze everything)
//   flush          : aborts an in-flight read, blocks acceptance this cycle
//   ifetch_*       : word fetch request (level) / done pulse + data
//   lsb_*          : load/store request (level) / done pulse + zero-extended data
//   io_buffer_full : holds off stores to the IO region
//   mem_din/mem_dout/mem_a/mem_wr : RAM bus; mem_din answers last cycle's mem_a
// Handshake: a requester holds *_valid until it sees its one-cycle *_done; no
// request is accepted while either done is high, so valid can be dropped in the
// done cycle without being accepted twice.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  ifetch_valid,
  input  logic [ADDR_WIDTH-1:0] ifetch_addr,
  output logic                  ifetch_done,
  output logic [DATA_WIDTH-1:0] ifetch_data,
  input  logic                  lsb_valid,
  input  logic                  lsb_is_write,
  input  logic [1:0]            lsb_size,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [DATA_WIDTH-1:0] lsb_wdata,
  output logic                  lsb_done,
  output logic [DATA_WIDTH-1:0] lsb_rdata,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  state_e                state_q, state_d;
  logic [1:0]            k_q, k_d;         // byte currently on the bus
  logic [1:0]            last_q, last_d;   // index of the final byte
  logic                  drain_q, drain_d; // read: waiting for the final byte
  logic                  owner_lsb_q, owner_lsb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;   // read assembly register
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  ifetch_done_q, ifetch_done_d;
  logic [DATA_WIDTH-1:0] ifetch_data_q, ifetch_data_d;
  logic                  lsb_done_q, lsb_done_d;
  logic [DATA_WIDTH-1:0] lsb_rdata_q, lsb_rdata_d;

  logic [1:0]            k_inc;
  logic [1:0]            rd_idx;
  logic [DATA_WIDTH-1:0] data_cap;
  logic [ADDR_WIDTH-1:0] next_a;
  logic                  wr_stall;
  logic                  lsb_accept;

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    last_d        = last_q;
    drain_d       = drain_q;
    owner_lsb_d   = owner_lsb_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    data_d        = data_q;
    mem_a_d       = mem_a_q;
    mem_dout_d    = mem_dout_q;
    mem_wr_d      = 1'b0;
    ifetch_done_d = 1'b0;
    ifetch_data_d = ifetch_data_q;
    lsb_done_d    = 1'b0;
    lsb_rdata_d   = lsb_rdata_q;

    k_inc  = k_q + 2'd1;
    next_a = addr_q + ADDR_WIDTH'(k_inc);

    // mem_din carries the byte addressed in the previous cycle: byte k-1
    // while issuing, or the last byte during the drain cycle.
    rd_idx   = drain_q ? last_q : (k_q - 2'd1);
    data_cap = data_q;
    data_cap[{rd_idx, 3'b000} +: 8] = mem_din;

    // Stall test uses the address of the byte that would be written next.
    wr_stall = io_buffer_full &&
               is_io(mem_wr_q ? next_a[17:16] : mem_a_q[17:16]);

    lsb_accept = lsb_valid &&
                 !(lsb_is_write && io_buffer_full && is_io(lsb_addr[17:16]));

    case (state_q)
      ST_IDLE: begin
        if (!flush && !ifetch_done_q && !lsb_done_q) begin
          if (lsb_accept) begin
            owner_lsb_d = 1'b1;
            addr_d      = lsb_addr;
            wdata_d     = lsb_wdata;
            last_d      = last_idx(lsb_size);
            k_d         = 2'd0;
            drain_d     = 1'b0;
            data_d      = '0;
            mem_a_d     = lsb_addr;
            if (lsb_is_write) begin
              state_d    = ST_WRITE;
              mem_dout_d = lsb_wdata[7:0];
              mem_wr_d   = 1'b1;
            end else begin
              state_d    = ST_READ;
            end
          end else if (ifetch_valid) begin
            owner_lsb_d = 1'b0;
            addr_d      = ifetch_addr;
            last_d      = 2'd3;
            k_d         = 2'd0;
            drain_d     = 1'b0;
            data_d      = '0;
            mem_a_d     = ifetch_addr;
            state_d     = ST_READ;
          end
        end
      end

      ST_READ: begin
        if (flush) begin
          state_d = ST_IDLE;
          drain_d = 1'b0;
          mem_a_d = '0;
        end else if (drain_q) begin
          state_d = ST_IDLE;
          drain_d = 1'b0;
          if (owner_lsb_q) begin
            lsb_rdata_d = data_cap;
            lsb_done_d  = 1'b1;
          end else begin
            ifetch_data_d = data_cap;
            ifetch_done_d = 1'b1;
          end
        end else begin
          if (k_q != 2'd0) data_d = data_cap;
          if (k_q == last_q) begin
            drain_d = 1'b1;
            mem_a_d = '0;
          end else begin
            k_d     = k_inc;
            mem_a_d = next_a;
          end
        end
      end

      ST_WRITE: begin
        // mem_wr_q high means byte k is committed at this edge; low means
        // byte k is still pending behind an IO-full stall.
        if (mem_wr_q) begin
          if (k_q == last_q) begin
            state_d    = ST_IDLE;
            mem_a_d    = '0;
            lsb_done_d = 1'b1;
          end else begin
            k_d        = k_inc;
            mem_a_d    = next_a;
            mem_dout_d = wdata_q[{k_inc, 3'b000} +: 8];
            mem_wr_d   = !wr_stall;
          end
        end else begin
          mem_wr_d = !wr_stall;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      k_q           <= 2'd0;
      last_q        <= 2'd0;
      drain_q       <= 1'b0;
      owner_lsb_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      data_q        <= '0;
      mem_a_q       <= '0;
      mem_dout_q    <= '0;
      mem_wr_q      <= 1'b0;
      ifetch_done_q <= 1'b0;
      ifetch_data_q <= '0;
      lsb_done_q    <= 1'b0;
      lsb_rdata_q   <= '0;
    end else if (rdy_in) begin
      state_q       <= state_d;
      k_q           <= k_d;
      last_q        <= last_d;
      drain_q       <= drain_d;
      owner_lsb_q   <= owner_lsb_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      data_q        <= data_d;
      mem_a_q       <= mem_a_d;
      mem_dout_q    <= mem_dout_d;
      mem_wr_q      <= mem_wr_d;
      ifetch_done_q <= ifetch_done_d;
      ifetch_data_q <= ifetch_data_d;
      lsb_done_q    <= lsb_done_d;
      lsb_rdata_q   <= lsb_rdata_d;
    end
  end

  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign mem_wr      = mem_wr_q & rdy_in;  // no write strobe while paused
  assign ifetch_done = ifetch_done_q;
  assign ifetch_data = ifetch_data_q;
  assign lsb_done    = lsb_done_q;
  assign lsb_rdata   = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed accesses against a 4 KiB byte RAM model whose
// read port registers mem_a (and whose write port commits) only while rdy_in=1.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int W  = 50;  // {check_data, is_lsb, cycle[15:0], data[31:0]}
  localparam int WW = 56;  // {cycle[15:0], addr[31:0], byte[7:0]}

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        ifetch_valid, ifetch_done;
  logic [31:0] ifetch_addr, ifetch_data;
  logic        lsb_valid, lsb_is_write, lsb_done;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic        io_buffer_full;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]   ram [0:4095];
  logic [W-1:0] exp_q[$];
  logic [WW-1:0] wr_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  bit  prev_if = 1'b0;
  bit  prev_lsb = 1'b0;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .ifetch_valid(ifetch_valid), .ifetch_addr(ifetch_addr),
    .ifetch_done(ifetch_done), .ifetch_data(ifetch_data),
    .lsb_valid(lsb_valid), .lsb_is_write(lsb_is_write), .lsb_size(lsb_size),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done),
    .lsb_rdata(lsb_rdata), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // ---------------- clock / reset / RAM model ----------------
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_done(input bit chk, input bit is_lsb, input int at, input logic [31:0] d);
    exp_q.push_back({chk, is_lsb, at[15:0], d});
  endtask

  task automatic exp_wr(input int at, input logic [31:0] a, input logic [7:0] d);
    wr_q.push_back({at[15:0], a, d});
  endtask

  task automatic on_done(input bit is_lsb, input logic [31:0] d);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_done: port %0d data %0h at cycle %0d, none required", is_lsb, d, cyc);
    end else begin
      e = exp_q.pop_front();
      check("done_port", {63'b0, is_lsb}, {63'b0, e[48]});
      check("done_cycle", {48'b0, cyc[15:0]}, {48'b0, e[47:32]});
      if (e[49]) check("done_data", {32'b0, d}, {32'b0, e[31:0]});
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a done or a write.
  always @(negedge clk_in) begin
    logic [WW-1:0] we;
    if (mon_en && rdy_in) begin
      if (ifetch_done) begin
        check("ifetch_done_single", {63'b0, prev_if}, 64'd0);
        on_done(1'b0, ifetch_data);
      end
      if (lsb_done) begin
        check("lsb_done_single", {63'b0, prev_lsb}, 64'd0);
        on_done(1'b1, lsb_rdata);
      end
      prev_if  = ifetch_done;
      prev_lsb = lsb_done;
    end
    if (mon_en && mem_wr) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h at cycle %0d, none required", mem_a, mem_dout, cyc);
      end else begin
        we = wr_q.pop_front();
        check("wr_cycle", {48'b0, cyc[15:0]}, {48'b0, we[55:40]});
        check("wr_addr", {32'b0, mem_a}, {32'b0, we[39:8]});
        check("wr_data", {56'b0, mem_dout}, {56'b0, we[7:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_fetch(input logic [31:0] a);
    ifetch_addr  = a;
    ifetch_valid = 1'b1;
  endtask

  task automatic start_lsb(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    lsb_is_write = wr;
    lsb_size     = sz;
    lsb_addr     = a;
    lsb_wdata    = d;
    lsb_valid    = 1'b1;
  endtask

  task automatic wait_done(input bit is_lsb);
    int t = 0;
    while (!(is_lsb ? lsb_done : ifetch_done) && t < 60) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 60) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: port %0d no done within 60 cycles", is_lsb);
    end
    if (is_lsb) lsb_valid = 1'b0;
    else ifetch_valid = 1'b0;
  endtask

  // Request issued at negedge c is accepted at edge c+1; a read of n bytes
  // shows done at c+n+2, a write at c+n+1 with byte j on the bus at c+1+j.
  task automatic do_read(input bit is_lsb, input logic [1:0] sz, input logic [31:0] a,
                         input int nb, input logic [31:0] d);
    int c;
    @(negedge clk_in);
    c = cyc;
    if (is_lsb) start_lsb(1'b0, sz, a, 32'h0);
    else start_fetch(a);
    exp_done(1'b1, is_lsb, c + nb + 2, d);
    wait_done(is_lsb);
  endtask

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input int nb, input logic [31:0] d);
    int c;
    @(negedge clk_in);
    c = cyc;
    start_lsb(1'b1, sz, a, d);
    for (int j = 0; j < nb; j++) exp_wr(c + 1 + j, a + 32'(j), d[8*j +: 8]);
    exp_done(1'b0, 1'b1, c + nb + 1, 32'h0);
    wait_done(1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_a"}, {32'b0, mem_a}, 64'd0);
    check({tag, "_mem_dout"}, {56'b0, mem_dout}, 64'd0);
    check({tag, "_mem_wr"}, {63'b0, mem_wr}, 64'd0);
    check({tag, "_ifetch_done"}, {63'b0, ifetch_done}, 64'd0);
    check({tag, "_ifetch_data"}, {32'b0, ifetch_data}, 64'd0);
    check({tag, "_lsb_done"}, {63'b0, lsb_done}, 64'd0);
    check({tag, "_lsb_rdata"}, {32'b0, lsb_rdata}, 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c;
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    ifetch_valid = 1'b0; ifetch_addr = '0;
    lsb_valid = 1'b0; lsb_is_write = 1'b0; lsb_size = 2'b00; lsb_addr = '0; lsb_wdata = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h201] = 8'h80; ram[12'h202] = 8'hFF;
    ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_outputs_zero("reset");
    rst_in = 1'b0;
    mon_en = 1'b1;

    do_read(1'b0, SIZE_WORD, 32'h100, 4, 32'h00000513);        // fetch, 6 cycles
    do_read(1'b1, SIZE_BYTE, 32'h201, 1, 32'h00000080);        // load byte
    do_read(1'b1, SIZE_HALF, 32'h201, 2, 32'h0000FF80);        // misaligned half
    do_store(SIZE_WORD, 32'h300, 4, 32'hDEADBEEF);
    do_read(1'b1, SIZE_WORD, 32'h300, 4, 32'hDEADBEEF);
    do_read(1'b1, 2'b11, 32'h100, 4, 32'h00000513);            // illegal size = word
    do_read(1'b0, SIZE_WORD, 32'hFFFFFFFE, 4, 32'h44332211);   // address wrap

    // Both requesters at once: load first, fetch after the bubble.
    @(negedge clk_in);
    c = cyc;
    start_fetch(32'h100);
    start_lsb(1'b0, SIZE_BYTE, 32'h202, 32'h0);
    exp_done(1'b1, 1'b1, c + 3, 32'h000000FF);
    exp_done(1'b1, 1'b0, c + 10, 32'h00000513);
    wait_done(1'b1);
    wait_done(1'b0);

    // Flush a fetch while byte 2 is on the bus; no done, idle straight after.
    @(negedge clk_in);
    c = cyc;
    start_fetch(32'h100);
    repeat (3) @(negedge clk_in);
    check("flush_pre_mem_a", {32'b0, mem_a}, 64'h102);
    flush = 1'b1;
    ifetch_valid = 1'b0;
    @(negedge clk_in);
    flush = 1'b0;
    check("flush_mem_a", {32'b0, mem_a}, 64'd0);
    c = cyc;
    start_lsb(1'b0, SIZE_BYTE, 32'h201, 32'h0);
    exp_done(1'b1, 1'b1, c + 3, 32'h00000080);
    wait_done(1'b1);

    // Flush during a store does not disturb it.
    @(negedge clk_in);
    c = cyc;
    start_lsb(1'b1, SIZE_HALF, 32'h500, 32'h00001234);
    exp_wr(c + 1, 32'h500, 8'h34);
    exp_wr(c + 2, 32'h501, 8'h12);
    exp_done(1'b0, 1'b1, c + 3, 32'h0);
    @(negedge clk_in);
    flush = 1'b1;
    @(negedge clk_in);
    flush = 1'b0;
    wait_done(1'b1);
    do_read(1'b1, SIZE_HALF, 32'h500, 2, 32'h00001234);

    // IO store held off in idle for 3 cycles by io_buffer_full.
    @(negedge clk_in);
    c = cyc;
    io_buffer_full = 1'b1;
    start_lsb(1'b1, SIZE_WORD, 32'h30000, 32'hCAFEF00D);
    exp_wr(c + 4, 32'h30000, 8'h0D);
    exp_wr(c + 5, 32'h30001, 8'hF0);
    exp_wr(c + 6, 32'h30002, 8'hFE);
    exp_wr(c + 7, 32'h30003, 8'hCA);
    exp_done(1'b0, 1'b1, c + 8, 32'h0);
    repeat (3) @(negedge clk_in);
    io_buffer_full = 1'b0;
    wait_done(1'b1);

    // IO store stalled for one cycle between its two bytes.
    @(negedge clk_in);
    c = cyc;
    start_lsb(1'b1, SIZE_HALF, 32'h30010, 32'h0000BEEF);
    exp_wr(c + 1, 32'h30010, 8'hEF);
    exp_wr(c + 3, 32'h30011, 8'hBE);
    exp_done(1'b0, 1'b1, c + 4, 32'h0);
    @(negedge clk_in);
    io_buffer_full = 1'b1;
    @(negedge clk_in);
    io_buffer_full = 1'b0;
    wait_done(1'b1);

    // Two paused cycles in the middle of a word load.
    @(negedge clk_in);
    c = cyc;
    start_lsb(1'b0, SIZE_WORD, 32'h300, 32'h0);
    exp_done(1'b1, 1'b1, c + 8, 32'hDEADBEEF);
    repeat (2) @(negedge clk_in);
    rdy_in = 1'b0;
    @(negedge clk_in);
    check("pause_mem_a", {32'b0, mem_a}, 64'h301);
    @(negedge clk_in);
    rdy_in = 1'b1;
    wait_done(1'b1);

    // One paused cycle during a byte store: strobe masked, write retried.
    @(negedge clk_in);
    c = cyc;
    start_lsb(1'b1, SIZE_BYTE, 32'h700, 32'h0000005A);
    exp_wr(c + 2, 32'h700, 8'h5A);
    exp_done(1'b0, 1'b1, c + 3, 32'h0);
    @(posedge clk_in);
    #1 rdy_in = 1'b0;
    @(negedge clk_in);
    check("pause_mem_wr", {63'b0, mem_wr}, 64'd0);
    @(posedge clk_in);
    #1 rdy_in = 1'b1;
    wait_done(1'b1);
    do_read(1'b1, SIZE_BYTE, 32'h700, 1, 32'h0000005A);

    // Reset in the middle of a word store: two bytes land, outputs clear.
    @(negedge clk_in);
    c = cyc;
    start_lsb(1'b1, SIZE_WORD, 32'h600, 32'h11223344);
    exp_wr(c + 1, 32'h600, 8'h44);
    exp_wr(c + 2, 32'h601, 8'h33);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    lsb_valid = 1'b0;
    @(negedge clk_in);
    check_outputs_zero("midreset");
    rst_in = 1'b0;
    do_read(1'b1, SIZE_WORD, 32'h600, 4, 32'h00003344);
    do_read(1'b0, SIZE_WORD, 32'h100, 4, 32'h00000513);

    repeat (5) @(negedge clk_in);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
